// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM->WB stage stream bundle
//
// Purpose: groups the MEM-side input stream and WB-side output stream of the
// MEM/WB elastic stage into one bundle.
// Ports (signals):
//   in_valid/in_ready         MEM-side handshake
//   in_reg_write, in_mem_to_reg, in_read_data, in_result, in_write_reg, in_pc
//                             MEM-side payload
//   out_valid/out_ready       WB-side handshake
//   out_reg_write, out_write_reg, out_wb_data, out_pc
//                             WB-side payload
// Modports: master = producer/consumer environment, slave = the stage itself.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [DATA_W-1:0] in_read_data;
  logic [DATA_W-1:0] in_result;
  logic [REG_AW-1:0] in_write_reg;
  logic [PC_W-1:0]   in_pc;

  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic [REG_AW-1:0] out_write_reg;
  logic [DATA_W-1:0] out_wb_data;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_read_data, in_result,
           in_write_reg, in_pc, out_ready,
    input  in_ready, out_valid, out_reg_write, out_write_reg, out_wb_data, out_pc
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_read_data, in_result,
           in_write_reg, in_pc, out_ready,
    output in_ready, out_valid, out_reg_write, out_write_reg, out_wb_data, out_pc
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic MEM->WB pipeline stage with two-entry skid buffer
//
// Purpose: holds up to two in-flight instructions between the data-memory
// stage and the register-file write port, with back-pressure, flush and a
// pre-selected write-back value.
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   flush         synchronous flush of all held entries
//   bus           mem_wb_stage_if.slave stream bundle (input and output streams)
//   retire_count  count of completed output handshakes (wraps)
module mem_wb_stage #(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int PC_W             = 32,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  mem_wb_stage_if.slave        bus,
  output logic [31:0]          retire_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] write_reg;
    logic [PC_W-1:0]   pc;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      h_q, h_d;
  entry_t      s_q, s_d;
  entry_t      in_entry;
  logic [31:0] retire_count_q, retire_count_d;

  logic h_valid;
  logic s_valid;
  logic accept;
  logic consume;

  // Valid bits are encoded in the state: H is valid in ONE/TWO, S only in TWO.
  assign h_valid = (state_q != EMPTY);
  assign s_valid = (state_q == TWO);

  // in_ready decodes registered state only, so there is no path from out_ready.
  assign bus.in_ready  = !s_valid;
  assign bus.out_valid = h_valid;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = h_valid && bus.out_ready;

  assign in_entry = '{
    reg_write:  bus.in_reg_write,
    mem_to_reg: bus.in_mem_to_reg,
    read_data:  bus.in_read_data,
    result:     bus.in_result,
    write_reg:  bus.in_write_reg,
    pc:         bus.in_pc
  };

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          h_d     = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          // Head leaves while the new entry takes its place.
          h_d = in_entry;
        end else if (accept) begin
          s_d     = in_entry;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          h_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any load; payload is left untouched, only validity drops.
    if (flush) begin
      state_d = EMPTY;
      h_d     = h_q;
      s_d     = s_q;
    end
  end

  // A handshake completing on the flush edge still retires.
  assign retire_count_d = consume ? retire_count_q + 32'd1 : retire_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= EMPTY;
      h_q            <= '0;
      s_q            <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      s_q            <= s_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.out_reg_write = h_valid && h_q.reg_write &&
                             !(ZERO_REG_DISCARD && (h_q.write_reg == '0));
  assign bus.out_write_reg = h_q.write_reg;
  assign bus.out_wb_data   = h_q.mem_to_reg ? h_q.read_data : h_q.result;
  assign bus.out_pc        = h_q.pc;
  assign retire_count      = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] retire_count;

  mem_wb_stage_if #(.DATA_W(32), .REG_AW(5), .PC_W(32)) bus ();

  mem_wb_stage #(
    .DATA_W(32), .REG_AW(5), .PC_W(32), .ZERO_REG_DISCARD(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] res;
    logic [4:0]  wr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mcount;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic compare();
    ent_t e;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, mq.size() < 2});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() > 0});
    chk("retire_count", {32'd0, retire_count}, {32'd0, mcount});
    if (mq.size() > 0) begin
      e = mq[0];
      chk("out_pc", {32'd0, bus.out_pc}, {32'd0, e.pc});
      chk("out_wb_data", {32'd0, bus.out_wb_data}, {32'd0, e.m2r ? e.rd : e.res});
      chk("out_write_reg", {59'd0, bus.out_write_reg}, {59'd0, e.wr});
      chk("out_reg_write", {63'd0, bus.out_reg_write}, {63'd0, e.rw && (e.wr != 5'd0)});
    end else begin
      chk("out_reg_write_idle", {63'd0, bus.out_reg_write}, 64'd0);
    end
  endtask

  // One clock: the model advances on the same edge the DUT does.
  task automatic step();
    ent_t cur;
    logic acc;
    logic con;
    @(posedge clk);
    cur.rw  = bus.in_reg_write;
    cur.m2r = bus.in_mem_to_reg;
    cur.rd  = bus.in_read_data;
    cur.res = bus.in_result;
    cur.wr  = bus.in_write_reg;
    cur.pc  = bus.in_pc;
    acc = bus.in_valid && (mq.size() < 2);
    con = (mq.size() > 0) && bus.out_ready;
    if (con) mcount = mcount + 32'd1;
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rw,
                       input logic m2r, input logic [31:0] rd,
                       input logic [31:0] res, input logic [4:0] wr);
    bus.in_valid      = v;
    bus.in_pc         = pc;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_read_data  = rd;
    bus.in_result     = res;
    bus.in_write_reg  = wr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    mcount = 32'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mcount = 32'd0;
    rst    = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);

    // Reset values.
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_reg_write", {63'd0, bus.out_reg_write}, 64'd0);
    chk("rst_out_wb_data", {32'd0, bus.out_wb_data}, 64'd0);
    chk("rst_out_pc", {32'd0, bus.out_pc}, 64'd0);
    chk("rst_out_write_reg", {59'd0, bus.out_write_reg}, 64'd0);
    chk("rst_retire_count", {32'd0, retire_count}, 64'd0);
    rst = 1'b1;

    // Streaming at full throughput.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 32'h101 + 32'(4 * i), 5'(i + 1));
      step();
      chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("stream_out_pc", {32'd0, bus.out_pc}, {32'd0, 32'h100 + 32'(4 * i)});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("stream_retire", {32'd0, retire_count}, 64'd4);

    // Skid: two absorbed, third held until room.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 32'h201, 5'd3); step();
    drive(1'b1, 32'h204, 1'b1, 1'b0, 32'h0, 32'h205, 5'd4); step();
    drive(1'b1, 32'h208, 1'b1, 1'b0, 32'h0, 32'h209, 5'd5); step();
    step();
    chk("skid_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("skid_head_pc", {32'd0, bus.out_pc}, 64'h200);
    bus.out_ready = 1'b1;
    step();
    chk("skid_second_pc", {32'd0, bus.out_pc}, 64'h204);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("skid_third_pc", {32'd0, bus.out_pc}, 64'h208);
    step();
    chk("skid_retire", {32'd0, retire_count}, 64'd7);

    // Write-back mux and zero-register gating.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h280, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1, 5'd0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("mux_wb_data", {32'd0, bus.out_wb_data}, 64'hDEADBEEF);
    chk("zero_reg_gate", {63'd0, bus.out_reg_write}, 64'd0);
    bus.out_ready = 1'b1;
    step();

    // Flush in TWO with a simultaneous input.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2F0, 1'b1, 1'b0, 32'h0, 32'h2F1, 5'd6); step();
    drive(1'b1, 32'h2F4, 1'b1, 1'b0, 32'h0, 32'h2F5, 5'd7); step();
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 32'h301, 5'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("flush_no_0x300", {63'd0, bus.out_valid}, 64'd0);

    // Flush in ONE overrides an acceptable input; handshake on that edge retires.
    drive(1'b1, 32'h310, 1'b1, 1'b0, 32'h0, 32'h311, 5'd9); step();
    drive(1'b1, 32'h314, 1'b1, 1'b0, 32'h0, 32'h315, 5'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("flush_one_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_one_retire", {32'd0, retire_count}, 64'd9);

    // Asynchronous reset between edges while in TWO.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 32'h401, 5'd11); step();
    drive(1'b1, 32'h404, 1'b1, 1'b0, 32'h0, 32'h405, 5'd12); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("pre_arst_reg_write", {63'd0, bus.out_reg_write}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_out_reg_write", {63'd0, bus.out_reg_write}, 64'd0);
    chk("arst_retire_count", {32'd0, retire_count}, 64'd0);
    mq.delete();
    mcount = 32'd0;
    @(negedge clk);
    rst = 1'b1;

    // Counter wrap from a preset all-ones value.
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    mcount = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 32'h501, 5'd13); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("pre_wrap_count", {32'd0, retire_count}, 64'hFFFF_FFFF);
    step();
    chk("wrap_count", {32'd0, retire_count}, 64'd0);

    // Randomized traffic with back-pressure and occasional flush.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 1'($urandom), 1'($urandom),
            $urandom, $urandom, 5'($urandom_range(0, 31)));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline stage that replaces the fixed-width, always-enabled MEM/WB register with an elastic valid/ready stage. It holds up to two in-flight instructions in a two-entry skid buffer, supports stall (back-pressure) and flush, and presents a pre-selected write-back value. It sits between the data-memory stage and the register-file write port of the core, and also drives the WB forwarding path.

## Interface
- DATA_W, 32: width of read data, ALU result and write-back data.
- REG_AW, 5: register-address width.
- PC_W, 32: program-counter width.
- ZERO_REG_DISCARD, 1: when 1, a write to register 0 is presented with out_reg_write=0.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- in_reg_write  in  1  instruction writes the register file.
- in_mem_to_reg  in  1  write-back source: 1 = read data, 0 = result.
- in_read_data  in  DATA_W  data-memory read value.
- in_result  in  DATA_W  ALU/address result.
- in_write_reg  in  REG_AW  destination register.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB consumes head; transfer when out_valid && out_ready.
- out_reg_write  out  1  gated write enable for the register file.
- out_write_reg  out  REG_AW  head destination register.
- out_wb_data  out  DATA_W  head mem_to_reg ? read_data : result.
- out_pc  out  PC_W  head PC.
- retire_count  out  32  number of completed output handshakes.

## Operation
- Storage: a head register (H) and a skid register (S), each holding {valid, reg_write, mem_to_reg, read_data, result, write_reg, pc}.
- States: EMPTY (neither entry valid), ONE (H only), TWO (H and S). S is never valid while H is empty.
- in_ready = !S.valid. It is a register output only, with no combinational path from out_ready.
- EMPTY: on input acceptance, load H, then go to ONE.
- ONE, accept with no consume: load S, then go to TWO. Consume with no accept: go to EMPTY. Accept and consume together: load H with the input and stay in ONE.
- TWO: in_ready=0. On consume, move S into H, clear S, and go to ONE.
- Order is strictly FIFO. No entry is ever dropped or duplicated unless a flush occurs.
- Flush: on the next edge, clear H.valid and S.valid and go to EMPTY. Flush overrides a simultaneous input acceptance: the input is discarded. A simultaneous output handshake still counts in retire_count.
- out_valid = H.valid. out_reg_write = H.valid && H.reg_write && !(ZERO_REG_DISCARD && H.write_reg==0).
- out_wb_data is combinational from H. Payload registers hold their last value when invalid; only the valid bits are cleared by flush.
- retire_count increments by 1 on each output handshake and wraps from 2^32−1 to 0.

## Timing
- Reset (rst low, asynchronous): state=EMPTY, all valid bits 0, in_ready=1, out_valid=0, out_reg_write=0, all payload fields 0, out_wb_data=0, out_pc=0, retire_count=0. Deassertion is synchronised by the system; the first acceptance can occur on the first edge after release.
- Latency: input accepted at edge N appears with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Back-pressure: if out_ready is low, the first two inputs are absorbed. in_ready falls the cycle after the second acceptance.
- After out_ready rises in TWO, in_ready returns to 1 after that edge.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Test plan
- Streaming: out_ready=1, push pc=0x100..0x10C (4 instr, result=pc+1) → out_pc follows 1 cycle later, in_ready always 1, retire_count=4.
- Skid: out_ready=0, push pc=0x200, 0x204, 0x208 held → only 0x200 and 0x204 accepted, in_ready=0. Then raise out_ready → outputs 0x200, 0x204, 0x208 in order, no loss.
- Mux/gate: mem_to_reg=1, read_data=0xDEADBEEF, result=0x1 → out_wb_data=0xDEADBEEF. reg_write=1, write_reg=0, ZERO_REG_DISCARD=1 → out_reg_write=0.
- Flush in TWO together with in_valid=1 (pc=0x300) → next cycle out_valid=0, in_ready=1, and 0x300 never appears.
- Async reset asserted between edges while in TWO → out_valid, out_reg_write and retire_count are 0 immediately.
- Counter wrap: preset via 2^32−1 handshakes (forced), then one more handshake → retire_count=0.
